// File: rtl/rf_arb_pkg.sv
// Shared constants for the register-file write-port arbiter.
// Requester indices follow the write-back priority order.
package rf_arb_pkg;

   localparam int NUM_REQ = 3;
   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 32;
   localparam int CNT_W   = 16;
   localparam int PTR_W   = 2;

   localparam int REQ_ALU = 0;
   localparam int REQ_MEM = 1;
   localparam int REQ_MDU = 2;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Write-back request bundle and register-file write side.
// Master = requesters/observer, slave = the arbiter.
interface rf_write_arbiter_if
   import rf_arb_pkg::*;
#(
   parameter int NR = NUM_REQ,
   parameter int AW = ADDR_W,
   parameter int DW = DATA_W
);

   logic [NR-1:0]    req_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic             RegWre;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    writeData;
   logic [CNT_W-1:0] conflict_cnt;

   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, RegWre, wr_addr,
      input  writeData, conflict_cnt
   );

   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, RegWre, wr_addr,
      output writeData, conflict_cnt
   );

endinterface

// File: rtl/rf_arb_pick.sv
// Combinational grant picker: round-robin from rr_ptr when
// RF_WRITE_ARB_RR_EN is defined, else lowest valid index wins.
module rf_arb_pick
   import rf_arb_pkg::*;
#(
   parameter int N = NUM_REQ,
   parameter int W = PTR_W
) (
   input  logic [N-1:0] req_valid,
`ifdef RF_WRITE_ARB_RR_EN
   input  logic [W-1:0] rr_ptr,
`endif
   output logic [N-1:0] grant,
   output logic [W-1:0] gnt_idx
);

   logic found;

`ifdef RF_WRITE_ARB_RR_EN
   int j;

   // Walk N slots starting at rr_ptr, wrapping modulo N.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(rr_ptr) + k) % N;
         if (!found && req_valid[j]) begin
            grant[j] = 1'b1;
            gnt_idx  = W'(j);
            found    = 1'b1;
         end
      end
   end
`else
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && req_valid[k]) begin
            grant[k] = 1'b1;
            gnt_idx  = W'(k);
            found    = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter with registered write outputs.
// Round-robin when RF_WRITE_ARB_RR_EN is defined, else fixed priority.
module rf_write_arbiter #(
   parameter int NUM_REQ = rf_arb_pkg::NUM_REQ,
   parameter int ADDR_W  = rf_arb_pkg::ADDR_W,
   parameter int DATA_W  = rf_arb_pkg::DATA_W
) (
   input logic               CLK,
   input logic               Reset,
   rf_write_arbiter_if.slave bus
);

   import rf_arb_pkg::*;

   logic [NUM_REQ-1:0] grant;
   logic [PTR_W-1:0]   gidx;
   logic               fire;
   logic               multi;
   logic [ADDR_W-1:0]  g_addr;
   logic [DATA_W-1:0]  g_data;

   logic               wre_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  data_q;
   logic [CNT_W-1:0]   cnt_q;

`ifdef RF_WRITE_ARB_RR_EN
   logic [PTR_W-1:0]   rr_ptr;
`endif

   rf_arb_pick #(
      .N (NUM_REQ),
      .W (PTR_W)
   ) u_pick (
      .req_valid (bus.req_valid),
`ifdef RF_WRITE_ARB_RR_EN
      .rr_ptr    (rr_ptr),
`endif
      .grant     (grant),
      .gnt_idx   (gidx)
   );

   // No grant may leak out while reset is held.
   assign bus.req_ready = Reset ? grant : '0;
   assign fire   = |bus.req_ready;
   assign multi  = $countones(bus.req_valid) >= 2;
   assign g_addr = bus.req_addr[int'(gidx)*ADDR_W +: ADDR_W];
   assign g_data = bus.req_data[int'(gidx)*DATA_W +: DATA_W];

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         wre_q  <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         // Writes to x0 are consumed but never enabled.
         wre_q <= fire && (g_addr != '0);
         if (fire) begin
            addr_q <= g_addr;
            data_q <= g_data;
         end
         if (multi && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

`ifdef RF_WRITE_ARB_RR_EN
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         rr_ptr <= '0;
      end else if (fire) begin
         rr_ptr <= (int'(gidx) == NUM_REQ - 1) ?
                   '0 : gidx + 1'b1;
      end
   end
`endif

   assign bus.RegWre       = wre_q;
   assign bus.wr_addr      = addr_q;
   assign bus.writeData    = data_q;
   assign bus.conflict_cnt = cnt_q;

endmodule
